// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns the core's combinational load/store request into a valid/ready bus transaction
// Ports: clk/rst_n (sync, active-low); req_* from the core ctrl stage; stall holds the core;
// load_valid/load_data/err report completion; bus_req_* / bus_rsp_* form the data-bus handshake.
module dmem_bus_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_read,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  input  logic [2:0]              req_funct3,
  output logic                    stall,
  output logic                    load_valid,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic                    err,
  output logic                    bus_req_valid,
  input  logic                    bus_req_ready,
  output logic                    bus_req_we,
  output logic [ADDR_WIDTH-1:0]   bus_req_addr,
  output logic [DATA_WIDTH-1:0]   bus_req_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_req_wstrb,
  input  logic                    bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   bus_rsp_rdata,
  input  logic                    bus_rsp_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] f3;
  logic [1:0] a_lo;
  logic req, bad, busy, timeout;
  logic [DATA_WIDTH-1:0] shifted, aligned;
  assign req  = req_read | req_write;
  // undefined funct3 codes and misaligned H/W accesses fault without touching the bus
  assign bad  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00);
  assign busy = (state == REQ) || (state == WAIT_RSP);
  // cnt is 0 on the first REQ cycle, so this fires after TIMEOUT_CYCLES cycles in REQ+WAIT_RSP
  assign timeout = busy && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign shifted = bus_rsp_rdata >> {a_lo, 3'b000};
  assign aligned = (f3[1:0] == 2'b00) ? {{(DATA_WIDTH-8){~f3[2] & shifted[7]}}, shifted[7:0]} :
                   (f3[1:0] == 2'b01) ? {{(DATA_WIDTH-16){~f3[2] & shifted[15]}}, shifted[15:0]} :
                   bus_rsp_rdata;
  always_comb begin
    state_nx      = IDLE;
    stall         = 1'b0;
    bus_req_valid = 1'b0;
    unique case (state)
      IDLE: begin
        state_nx = req ? (bad ? DONE : REQ) : IDLE;
        stall    = req;
      end
      REQ: begin
        state_nx      = timeout ? DONE : bus_req_ready ? WAIT_RSP : REQ;
        stall         = 1'b1;
        bus_req_valid = 1'b1;
      end
      WAIT_RSP: begin
        state_nx = (bus_rsp_valid || timeout) ? DONE : WAIT_RSP;
        stall    = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      f3            <= '0;
      a_lo          <= '0;
      bus_req_we    <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_wstrb <= '0;
      load_valid    <= 1'b0;
      load_data     <= '0;
      err           <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= busy ? cnt + 1'b1 : '0;
      load_valid <= 1'b0;
      load_data  <= '0;
      err        <= 1'b0;
      if (state == IDLE && req) begin
        f3            <= req_funct3;
        a_lo          <= req_addr[1:0];
        bus_req_we    <= req_write;
        bus_req_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        bus_req_wdata <= req_wdata;
        bus_req_wstrb <= req_write ? req_wstrb : '0;
        err           <= bad;
      end
      // a response arriving on the timeout cycle still wins over the timeout
      if (state == WAIT_RSP && bus_rsp_valid) begin
        err        <= bus_rsp_err;
        load_valid <= ~bus_req_we & ~bus_rsp_err;
        load_data  <= bus_req_we ? '0 : aligned;
      end else if (timeout) begin
        err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: directed checks of dmem_bus_bridge against hand-computed results
module tb_dmem_bus_bridge;
  logic clk = 0, rst_n = 0;
  logic req_read = 0, req_write = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_wstrb = 0;
  logic [2:0] req_funct3 = 0;
  logic stall, load_valid, err, bus_req_valid, bus_req_we;
  logic [31:0] load_data, bus_req_addr, bus_req_wdata, bus_rsp_rdata = 0;
  logic [3:0] bus_req_wstrb;
  logic bus_req_ready = 0, bus_rsp_valid = 0, bus_rsp_err = 0;
  int n_cmp = 0, n_bad = 0;
  int o_stall, o_valid;
  logic o_done, o_stable, o_lv, o_err, o_we;
  logic [31:0] o_ld, o_addr, o_wdata;
  logic [3:0] o_wstrb;

  dmem_bus_bridge dut (
    .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_funct3(req_funct3),
    .stall(stall), .load_valid(load_valid), .load_data(load_data), .err(err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from IDLE to DONE with a simple bus model:
  // ready rises after ready_lat valid cycles, the response comes the cycle after acceptance.
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input logic [2:0] f3,
                       input int ready_lat, input logic send_rsp, input logic [31:0] rdata,
                       input logic rerr);
    logic acc;
    int waited;
    acc = 0; waited = 0;
    o_stall = 0; o_valid = 0; o_done = 0; o_stable = 1;
    req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata;
    req_wstrb = wstrb; req_funct3 = f3;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (!stall) begin
        o_done = 1; o_lv = load_valid; o_err = err; o_ld = load_data;
        break;
      end
      o_stall++;
      bus_rsp_valid = send_rsp && acc;
      bus_rsp_rdata = rdata;
      bus_rsp_err = rerr;
      if (bus_req_valid) begin
        if (o_valid == 0) begin
          o_we = bus_req_we; o_addr = bus_req_addr; o_wdata = bus_req_wdata; o_wstrb = bus_req_wstrb;
        end else if (o_we !== bus_req_we || o_addr !== bus_req_addr ||
                     o_wdata !== bus_req_wdata || o_wstrb !== bus_req_wstrb) o_stable = 0;
        o_valid++;
        bus_req_ready = (waited >= ready_lat);
        waited++;
      end else bus_req_ready = 0;
      acc = bus_req_valid && bus_req_ready;
      @(posedge clk);
    end
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_err = 0;
    req_read = 0; req_write = 0;
    check("done_reached", {31'b0, o_done}, 32'd1);
    tick();
  endtask

  initial begin
    tick(); tick();
    check("rst_stall", {31'b0, stall}, 0);
    check("rst_outs", {27'b0, load_valid, err, bus_req_valid, bus_req_we, |bus_req_wstrb}, 0);
    check("rst_addr", bus_req_addr, 0);
    check("rst_ld", load_data, 0);
    rst_n = 1;
    tick();

    do_op(1, 0, 32'h1003, 0, 4'h0, 3'b000, 0, 1, 32'h8012_3456, 0);
    check("lb_addr", o_addr, 32'h1000);
    check("lb_wstrb", {28'b0, o_wstrb}, 0);
    check("lb_stall", o_stall, 3);
    check("lb_ld", o_ld, 32'hFFFF_FF80);
    check("lb_lv_err", {30'b0, o_lv, o_err}, 32'b10);
    check("idle_after", {31'b0, stall}, 0);

    do_op(1, 0, 32'h2002, 0, 4'h0, 3'b101, 0, 1, 32'hBEEF_1234, 0);
    check("lhu_ld", o_ld, 32'h0000_BEEF);
    do_op(1, 0, 32'h2002, 0, 4'h0, 3'b001, 0, 1, 32'hBEEF_1234, 0);
    check("lh_ld", o_ld, 32'hFFFF_BEEF);
    do_op(1, 0, 32'h2001, 0, 4'h0, 3'b100, 0, 1, 32'hBEEF_F234, 0);
    check("lbu_ld", o_ld, 32'h0000_00F2);

    do_op(0, 1, 32'h3000, 32'hDEAD_BEEF, 4'hF, 3'b010, 3, 1, 32'h5555_5555, 0);
    check("sw_valid_cycles", o_valid, 4);
    check("sw_stable", {31'b0, o_stable}, 1);
    check("sw_we", {31'b0, o_we}, 1);
    check("sw_fields", o_wdata, 32'hDEAD_BEEF);
    check("sw_wstrb_addr", {o_wstrb, o_addr[27:0]}, 32'hF000_3000);
    check("sw_stall", o_stall, 6);
    check("sw_done", {o_ld[29:0], o_lv, o_err}, 0);

    do_op(1, 1, 32'h3004, 32'h1, 4'h1, 3'b000, 0, 1, 0, 1);
    check("rw_as_write", {31'b0, o_we}, 1);
    check("store_rsp_err", {30'b0, o_lv, o_err}, 32'b01);

    do_op(1, 0, 32'h1001, 0, 4'h0, 3'b010, 0, 1, 0, 0);
    check("mis_valid", o_valid, 0);
    check("mis_stall", o_stall, 1);
    check("mis_err", {30'b0, o_lv, o_err}, 32'b01);
    do_op(1, 0, 32'h1000, 0, 4'h0, 3'b011, 0, 1, 0, 0);
    check("undef_f3", {o_valid[29:0], o_lv, o_err}, 32'b01);

    do_op(1, 0, 32'h4000, 0, 4'h0, 3'b010, 0, 1, 32'hCAFE_0000, 1);
    check("rsp_err_load", {30'b0, o_lv, o_err}, 32'b01);

    do_op(1, 0, 32'h5000, 0, 4'h0, 3'b010, 0, 0, 0, 0);
    check("to_stall", o_stall, 256);
    check("to_err", {30'b0, o_lv, o_err}, 32'b01);
    check("to_ld", o_ld, 0);
    bus_rsp_valid = 1; bus_rsp_rdata = 32'h1234_5678;
    tick();
    bus_rsp_valid = 0;
    check("late_rsp", {29'b0, stall, load_valid, err}, 0);
    tick();
    check("late_rsp2", load_data, 0);

    req_read = 1; req_addr = 32'h4008; req_funct3 = 3'b010; bus_req_ready = 1;
    tick();
    check("rst_mid_req", {31'b0, bus_req_valid}, 1);
    tick();
    bus_req_ready = 0;
    rst_n = 0; req_read = 0;
    tick();
    rst_n = 1; bus_rsp_valid = 1; bus_rsp_rdata = 32'hFFFF_FFFF;
    tick();
    bus_rsp_valid = 0;
    check("rst_mid_ctl", {28'b0, stall, load_valid, err, bus_req_valid}, 0);
    check("rst_mid_data", load_data | bus_req_addr | bus_req_wdata, 0);
    tick();
    check("rst_mid_after", {29'b0, stall, load_valid, err}, 0);

    do_op(1, 0, 32'h0, 0, 4'h0, 3'b010, 0, 1, 32'h1122_3344, 0);
    check("lw_ld", o_ld, 32'h1122_3344);
    check("lw_lv", {30'b0, o_lv, o_err}, 32'b10);
    check("lw_stall", o_stall, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the data-memory input/control stage of the single-cycle core.
- Takes its combinational read/write/addr/wdata/wstrb request and converts it into a valid/ready request plus a response transaction on the data bus.
- Stalls the core while the transaction is outstanding.
- Returns load data already byte-aligned and sign/zero-extended for register writeback.

Parameters:
ADDR_WIDTH, 32, width of request and bus addresses
DATA_WIDTH, 32, data width; fixed at 32 for RV32I, byte lanes = DATA_WIDTH/8
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT_RSP before the transaction is abandoned with error

Ports:
clk  in  1  core clock; all logic on rising edge
rst_n  in  1  synchronous, active-low reset
req_read  in  1  load request from upstream ctrl stage
req_write  in  1  store request from upstream ctrl stage
req_addr  in  ADDR_WIDTH  byte address (ALU result)
req_wdata  in  DATA_WIDTH  store data, already lane-shifted upstream
req_wstrb  in  DATA_WIDTH/8  store byte strobes
req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
stall  out  1  hold PC/pipeline; core inputs stay stable while high
load_valid  out  1  load_data valid this cycle (DONE state, read only)
load_data  out  DATA_WIDTH  aligned, extended load result
err  out  1  access fault for the completing instruction (DONE only)
bus_req_valid  out  1  bus request valid
bus_req_ready  in  1  bus accepts request
bus_req_we  out  1  1 = write
bus_req_addr  out  ADDR_WIDTH  word-aligned address (req_addr with [1:0] cleared)
bus_req_wdata  out  DATA_WIDTH  registered store data
bus_req_wstrb  out  DATA_WIDTH/8  registered strobes; all zero for reads
bus_rsp_valid  in  1  response valid; earliest one cycle after request acceptance
bus_rsp_rdata  in  DATA_WIDTH  read data, full word
bus_rsp_err  in  1  bus fault, qualified by bus_rsp_valid

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, timeout counter 0. All registered outputs are 0: bus_req_*, load_data, load_valid, err. stall is 0 while in IDLE with no request. Reset mid-transaction drops the transaction; later rsp is ignored.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE + (req_read|req_write):
  - stall=1 combinationally.
  - Capture addr, wdata, wstrb, funct3 and we.
  - If both req_read and req_write are set, treat as write.
  - Misaligned access (H/HU with addr[0]=1; W with addr[1:0]!=0) goes to DONE with err=1 and no bus transaction.
  - Otherwise go to REQ.
- REQ: bus_req_valid=1, fields stable until bus_req_ready=1, then go to WAIT_RSP. stall=1.
- WAIT_RSP: on bus_rsp_valid, capture aligned data and bus_rsp_err, then go to DONE. stall=1. Any rsp_valid seen in IDLE or REQ is ignored.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT_RSP.
  - On reaching TIMEOUT_CYCLES, go to DONE with err=1 and load_data=0.
  - bus_req_valid drops.
- DONE:
  - stall=0, so the core retires the instruction this cycle.
  - load_valid=1 only for reads without err.
  - err as captured.
  - Next state is unconditionally IDLE, so the still-present request is not re-issued.
- Load alignment:
  - shifted = rdata >> (addr[1:0]*8).
  - B: sign-extend shifted[7:0]. BU: zero-extend shifted[7:0].
  - H: sign-extend shifted[15:0]. HU: zero-extend shifted[15:0].
  - W: rdata.
  - Undefined funct3 codes (011, 110, 111): err=1, no bus transaction.
- Latency, zero-wait bus (ready immediate, rsp one cycle later): 4 cycles IDLE→REQ→WAIT_RSP→DONE, stall high for 3 cycles.
- Stores: load_data=0, load_valid=0. err reflects bus_rsp_err.

Test Plan:
- LB addr 0x1003, ready immediate, rsp 0x80123456 one cycle later -> bus_req_addr 0x1000, wstrb 0, stall high 3 cycles, DONE load_data 0xFFFFFF80, load_valid=1, err=0.
- LHU addr 0x2002, rsp 0xBEEF1234 -> load_data 0x0000BEEF. Repeat with LH -> 0xFFFFBEEF.
- SW addr 0x3000, wdata 0xDEADBEEF, wstrb 0xF, ready low 3 cycles -> bus_req_valid held with stable fields 4 cycles, we=1, stall high until DONE, load_valid=0.
- LW addr 0x1001 -> no bus_req_valid ever, DONE next cycle with err=1, stall high exactly 1 cycle.
- LW with no rsp for TIMEOUT_CYCLES -> DONE with err=1, load_data 0. A late rsp_valid arriving in IDLE is ignored.
- rst_n low during WAIT_RSP, then rsp arrives -> state IDLE, stall 0, all outputs 0. Next LW addr 0x0 with rsp 0x11223344 completes normally with load_data 0x11223344.
